ifetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the single-cycle core.
- Owns the fetch PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Buffers returned instructions, with their PCs, in a small queue toward decode.
- Applies redirects (taken branch, JAL/JALR) from execute, flushing the queue and discarding any in-flight response.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 53 +++++
 rtl/ifetch_ctrl.sv | 117 +++++++++++
 tb/tb_ifetch_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch block.
package fetch_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DROP
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries with same-cycle push/pop and a flush
// that takes priority over both.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  fetch_entry_t  push_entry,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output fetch_entry_t  head
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && (count != FULL);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         // NOTE: storage is cleared on reset so the head output reads zero while empty.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, responses queued toward decode,
// redirects flush the queue and discard whatever response is still in flight.
module ifetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              QDEPTH   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_pc,
   output logic [ILEN-1:0] dec_instr
);

   localparam int CW = $clog2(QDEPTH) + 1;
   localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

   fetch_state_t    state, state_nxt;
   logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
   logic [XLEN-1:0] inflight_pc, inflight_pc_nxt;
   logic [CW-1:0]   q_count;
   logic [CW-1:0]   count_after;
   fetch_entry_t    q_head;
   fetch_entry_t    push_entry;
   logic            push;
   logic            pop_req;
   logic            handshake;
   logic            unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   assign imem_req_valid = (state == REQ);
   assign imem_req_addr  = fetch_pc;
   assign handshake      = imem_req_valid && imem_req_ready;
   assign dec_valid      = (q_count != '0);
   assign dec_pc         = q_head.pc;
   assign dec_instr      = q_head.instr;
   assign pop_req        = dec_ready && dec_valid;
   assign push_entry     = '{pc: inflight_pc, instr: imem_rsp_data};
   // Occupancy once this cycle's response is pushed and any pop retires.
   assign count_after    = q_count + CW'(1) - CW'(pop_req);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         fetch_pc    <= RESET_PC;
         inflight_pc <= RESET_PC;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values regardless of block ordering.
         state       <= state_nxt;
         fetch_pc    <= fetch_pc_nxt;
         inflight_pc <= inflight_pc_nxt;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      state_nxt       = state;
      fetch_pc_nxt    = fetch_pc;
      inflight_pc_nxt = inflight_pc;
      push            = 1'b0;

      unique case (state)
         IDLE: if (q_count < QFULL) state_nxt = REQ;
         REQ: begin
            if (handshake) begin
               inflight_pc_nxt = fetch_pc;
               fetch_pc_nxt    = fetch_pc + PC_STEP;
               state_nxt       = WAIT;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               push      = 1'b1;
               state_nxt = (count_after < QFULL) ? REQ : IDLE;
            end
         end
         DROP: if (imem_rsp_valid) state_nxt = REQ;
         default: state_nxt = IDLE;
      endcase

      // Redirect wins; an accepted but unanswered request forces DROP.
      if (redirect_valid) begin
         fetch_pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
         push         = 1'b0;
         unique case (state)
            REQ:        state_nxt = handshake ? DROP : IDLE;
            WAIT, DROP: state_nxt = imem_rsp_valid ? IDLE : DROP;
            default:    state_nxt = IDLE;
         endcase
      end
   end

   fetch_queue #(
      .DEPTH(QDEPTH)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_entry(push_entry),
      .pop       (dec_ready),
      .flush     (redirect_valid),
      .count     (q_count),
      .head      (q_head)
   );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: behavioural imem with programmable latency,
// request/decode logs and per-scenario checks.
module tb_ifetch_ctrl;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_pc;
   logic [31:0] dec_instr;

   int total = 0;
   int bad   = 0;
   int mem_lat = 1;

   logic [31:0]  req_log [$];
   fetch_entry_t dec_log [$];

   always #5 clk = ~clk;

   ifetch_ctrl #(
      .RESET_PC(32'h0000_0100),
      .QDEPTH  (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_req_addr (imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .dec_valid     (dec_valid),
      .dec_ready     (dec_ready),
      .dec_pc        (dec_pc),
      .dec_instr     (dec_instr)
   );

   // Memory: instruction word is addr ^ 32'hDEAD_0000, returned mem_lat cycles on.
   initial begin
      logic        hs, r, pend;
      logic [31:0] haddr, paddr;
      int          cd;
      pend = 1'b0;
      cd = 0;
      paddr = '0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         hs    = imem_req_valid && imem_req_ready;
         haddr = imem_req_addr;
         r     = rst;
         @(posedge clk);
         #1;
         imem_rsp_valid = 1'b0;
         if (r) begin
            pend = 1'b0;
         end else begin
            if (hs) begin
               pend  = 1'b1;
               cd    = mem_lat;
               paddr = haddr;
            end
            if (pend) begin
               if (cd <= 1) begin
                  imem_rsp_valid = 1'b1;
                  imem_rsp_data  = paddr ^ 32'hDEAD_0000;
                  pend = 1'b0;
               end else begin
                  cd--;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
         if (!rst && dec_valid && dec_ready) begin
            fetch_entry_t e;
            e.pc    = dec_pc;
            e.instr = dec_instr;
            dec_log.push_back(e);
         end
      end
   end

   function automatic logic [31:0] req_at(int i);
      req_at = 'x;
      if (i < req_log.size()) req_at = req_log[i];
   endfunction

   function automatic logic [31:0] dpc_at(int i);
      dpc_at = 'x;
      if (i < dec_log.size()) dpc_at = dec_log[i].pc;
   endfunction

   function automatic logic [31:0] dinstr_at(int i);
      dinstr_at = 'x;
      if (i < dec_log.size()) dinstr_at = dec_log[i].instr;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      req_log.delete();
      dec_log.delete();
   endtask

   task automatic wait_hs(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: no request handshake within 20 cycles", name);
      end
   endtask

   task automatic wait_req_valid(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (imem_req_valid) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: imem_req_valid never rose within 20 cycles", name);
      end
   endtask

   task automatic test_reset();
      dec_ready = 1'b0;
      imem_req_ready = 1'b1;
      mem_lat = 1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
      total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
      total++; if (imem_req_addr !== 32'h100) begin bad++; $display("FAIL reset_req_addr: got %h want 00000100", imem_req_addr); end
      total++; if (dec_pc !== 32'h0) begin bad++; $display("FAIL reset_dec_pc: got %h want 0", dec_pc); end
      total++; if (dec_instr !== 32'h0) begin bad++; $display("FAIL reset_dec_instr: got %h want 0", dec_instr); end
      tick();
      rst = 1'b0;
      repeat (6) tick();
      @(negedge clk);
      total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL pre_midreset_dec_valid: got %b want 1", dec_valid); end
      tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL midreset_dec_valid: got %b want 0", dec_valid); end
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL midreset_req_valid: got %b want 0", imem_req_valid); end
      total++; if (imem_req_addr !== 32'h100) begin bad++; $display("FAIL midreset_req_addr: got %h want 00000100", imem_req_addr); end
   endtask

   task automatic test_stream();
      dec_ready = 1'b1;
      imem_req_ready = 1'b1;
      mem_lat = 1;
      do_reset();
      repeat (10) tick();
      total++; if (req_log.size() != 5) begin bad++; $display("FAIL stream_req_count: got %0d want 5", req_log.size()); end
      total++; if (req_at(0) !== 32'h100) begin bad++; $display("FAIL stream_req0: got %h want 00000100", req_at(0)); end
      total++; if (req_at(1) !== 32'h104) begin bad++; $display("FAIL stream_req1: got %h want 00000104", req_at(1)); end
      total++; if (req_at(2) !== 32'h108) begin bad++; $display("FAIL stream_req2: got %h want 00000108", req_at(2)); end
      total++; if (dec_log.size() != 4) begin bad++; $display("FAIL stream_dec_count: got %0d want 4", dec_log.size()); end
      total++; if (dpc_at(0) !== 32'h100) begin bad++; $display("FAIL stream_dec_pc0: got %h want 00000100", dpc_at(0)); end
      total++; if (dinstr_at(0) !== 32'hDEAD_0100) begin bad++; $display("FAIL stream_dec_instr0: got %h want dead0100", dinstr_at(0)); end
      total++; if (dpc_at(1) !== 32'h104) begin bad++; $display("FAIL stream_dec_pc1: got %h want 00000104", dpc_at(1)); end
      total++; if (dinstr_at(1) !== 32'hDEAD_0104) begin bad++; $display("FAIL stream_dec_instr1: got %h want dead0104", dinstr_at(1)); end
   endtask

   task automatic test_backpressure();
      dec_ready = 1'b0;
      imem_req_ready = 1'b1;
      mem_lat = 1;
      do_reset();
      repeat (12) tick();
      @(negedge clk);
      total++; if (req_log.size() != 2) begin bad++; $display("FAIL bp_req_count: got %0d want 2", req_log.size()); end
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
      total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL bp_dec_valid: got %b want 1", dec_valid); end
      total++; if (dec_pc !== 32'h100) begin bad++; $display("FAIL bp_dec_pc: got %h want 00000100", dec_pc); end
      tick();
      req_log.delete();
      dec_log.delete();
      dec_ready = 1'b1;
      repeat (10) tick();
      total++; if (req_at(0) !== 32'h108) begin bad++; $display("FAIL bp_resume_req: got %h want 00000108", req_at(0)); end
      total++; if (dpc_at(0) !== 32'h100) begin bad++; $display("FAIL bp_drain_pc0: got %h want 00000100", dpc_at(0)); end
      total++; if (dpc_at(1) !== 32'h104) begin bad++; $display("FAIL bp_drain_pc1: got %h want 00000104", dpc_at(1)); end
      total++; if (dinstr_at(1) !== 32'hDEAD_0104) begin bad++; $display("FAIL bp_drain_instr1: got %h want dead0104", dinstr_at(1)); end
   endtask

   task automatic test_redirect_wait();
      dec_ready = 1'b1;
      imem_req_ready = 1'b1;
      mem_lat = 3;
      do_reset();
      wait_hs("rw_first_req");
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect_valid = 1'b0;
      req_log.delete();
      dec_log.delete();
      repeat (12) tick();
      total++; if (req_at(0) !== 32'h200) begin bad++; $display("FAIL rw_next_req: got %h want 00000200", req_at(0)); end
      total++; if (dpc_at(0) !== 32'h200) begin bad++; $display("FAIL rw_first_dec_pc: got %h want 00000200", dpc_at(0)); end
      total++; if (dinstr_at(0) !== 32'hDEAD_0200) begin bad++; $display("FAIL rw_first_dec_instr: got %h want dead0200", dinstr_at(0)); end
   endtask

   task automatic test_redirect_rsp();
      dec_ready = 1'b0;
      imem_req_ready = 1'b1;
      mem_lat = 1;
      do_reset();
      wait_hs("rr_req0");
      tick();
      wait_hs("rr_req1");
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h300;
      @(negedge clk);
      total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL rr_pre_dec_valid: got %b want 1", dec_valid); end
      tick();
      redirect_valid = 1'b0;
      req_log.delete();
      dec_log.delete();
      dec_ready = 1'b1;
      @(negedge clk);
      total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL rr_flushed_dec_valid: got %b want 0", dec_valid); end
      repeat (10) tick();
      total++; if (req_at(0) !== 32'h300) begin bad++; $display("FAIL rr_next_req: got %h want 00000300", req_at(0)); end
      total++; if (dpc_at(0) !== 32'h300) begin bad++; $display("FAIL rr_first_dec_pc: got %h want 00000300", dpc_at(0)); end
   endtask

   task automatic test_redirect_req();
      dec_ready = 1'b1;
      imem_req_ready = 1'b0;
      mem_lat = 1;
      do_reset();
      wait_req_valid("rq_req_up");
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h203;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rq_retract_valid: got %b want 0", imem_req_valid); end
      tick();
      @(negedge clk);
      total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL rq_reissue_valid: got %b want 1", imem_req_valid); end
      total++; if (imem_req_addr !== 32'h200) begin bad++; $display("FAIL rq_reissue_addr: got %h want 00000200", imem_req_addr); end
      imem_req_ready = 1'b1;
   endtask

   task automatic test_wrap();
      dec_ready = 1'b1;
      imem_req_ready = 1'b0;
      mem_lat = 1;
      do_reset();
      wait_req_valid("wr_req_up");
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      req_log.delete();
      dec_log.delete();
      repeat (10) tick();
      total++; if (req_at(0) !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req0: got %h want fffffffc", req_at(0)); end
      total++; if (req_at(1) !== 32'h0) begin bad++; $display("FAIL wrap_req1: got %h want 00000000", req_at(1)); end
      total++; if (dpc_at(0) !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_dec_pc0: got %h want fffffffc", dpc_at(0)); end
      total++; if (dpc_at(1) !== 32'h0) begin bad++; $display("FAIL wrap_dec_pc1: got %h want 00000000", dpc_at(1)); end
      total++; if (dinstr_at(1) !== 32'hDEAD_0000) begin bad++; $display("FAIL wrap_dec_instr1: got %h want dead0000", dinstr_at(1)); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_redirect_rsp();
      test_redirect_req();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
